// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit pipeline memory stage.
// Holds the datapath defaults and the matrix-multiply sequencer state type.
package pipe_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_MAT_N  = 2;

    typedef enum logic [2:0] {
        MM_IDLE,
        MM_RD_A,
        MM_RD_B,
        MM_WR_C,
        MM_DONE
    } mm_state_t;
endpackage

// File: rtl/data_mem.sv
// Local data memory: one combinational read port and one synchronous write port.
// Contents are deliberately not reset.
module data_mem
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_stage.sv
// Memory stage: loads/stores on the local data memory plus a multi-cycle
// MAT_N x MAT_N matrix multiply that stalls the upstream pipeline while it runs.
//
// state | meaning
// IDLE  | normal ld/st; a matrix instruction here starts the multiply
// RD_A  | latch A[i][k]
// RD_B  | acc += A[i][k] * B[k][j]
// WR_C  | store acc to C[i][j], step to the next element
// DONE  | multiply retires into MEM/WB, pulses mm_done
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MAT_N  = DEF_MAT_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ALUResult_m,
    input  logic [DATA_W-1:0] WriteData_m,
    input  logic [DATA_W-1:0] pcplus1_m,
    input  logic [2:0]        destreg_m,
    input  logic              RegWrite_m,
    input  logic              MemWrite_m,
    input  logic              ResultSrc_m,
    input  logic              is_matrix_mult_m,
    output logic              mm_busy,
    output logic [DATA_W-1:0] ReadData_w,
    output logic [DATA_W-1:0] ALUResult_w,
    output logic [DATA_W-1:0] pcplus1_w,
    output logic [2:0]        destreg_w,
    output logic              RegWrite_w,
    output logic              ResultSrc_w,
    output logic              mm_done
);
    localparam int                MM_SZ    = MAT_N * MAT_N;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAT_N - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(MAT_N);
    localparam logic [ADDR_W-1:0] OFS_B    = ADDR_W'(MM_SZ);
    localparam logic [ADDR_W-1:0] OFS_C    = ADDR_W'(2 * MM_SZ);

    mm_state_t         r_state;
    mm_state_t         w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [ADDR_W-1:0] r_k;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_a_lat;

    logic              w_start;
    logic              w_last_i;
    logic              w_last_j;
    logic              w_last_k;
    logic [ADDR_W-1:0] w_addr_m;
    logic [ADDR_W-1:0] w_addr_a;
    logic [ADDR_W-1:0] w_addr_b;
    logic [ADDR_W-1:0] w_addr_c;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_prod;
    logic              w_we;

    assign w_addr_m = ADDR_W'(ALUResult_m);
    assign w_start  = (r_state == MM_IDLE) && is_matrix_mult_m;
    assign w_last_i = (r_i == LAST_IDX);
    assign w_last_j = (r_j == LAST_IDX);
    assign w_last_k = (r_k == LAST_IDX);

    assign mm_busy = w_start || (r_state == MM_RD_A) || (r_state == MM_RD_B)
                     || (r_state == MM_WR_C);

    // Base is latched at start; all address arithmetic wraps modulo the memory depth.
    assign w_addr_a = r_base + r_i * ROW_STEP + r_k;
    assign w_addr_b = r_base + OFS_B + r_k * ROW_STEP + r_j;
    assign w_addr_c = r_base + OFS_C + r_i * ROW_STEP + r_j;

    assign w_raddr = (r_state == MM_RD_A) ? w_addr_a :
                     (r_state == MM_RD_B) ? w_addr_b : w_addr_m;

    // Pipeline stores only go through for a plain instruction in IDLE.
    assign w_we    = (r_state == MM_WR_C) ||
                     ((r_state == MM_IDLE) && !is_matrix_mult_m && MemWrite_m);
    assign w_waddr = (r_state == MM_WR_C) ? w_addr_c : w_addr_m;
    assign w_wdata = (r_state == MM_WR_C) ? r_acc : WriteData_m;

    assign w_prod = r_a_lat * w_rdata;

    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MM_IDLE: if (is_matrix_mult_m) w_next_state = MM_RD_A;
            MM_RD_A: w_next_state = MM_RD_B;
            MM_RD_B: w_next_state = w_last_k ? MM_WR_C : MM_RD_A;
            MM_WR_C: w_next_state = (w_last_i && w_last_j) ? MM_DONE : MM_RD_A;
            MM_DONE: w_next_state = MM_IDLE;
            default: w_next_state = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base  <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_a_lat <= '0;
        end else begin
            case (r_state)
                MM_IDLE: begin
                    if (is_matrix_mult_m) begin
                        r_base <= w_addr_m;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_k    <= '0;
                        r_acc  <= '0;
                    end
                end
                MM_RD_A: r_a_lat <= w_rdata;
                MM_RD_B: begin
                    r_acc <= r_acc + w_prod;
                    if (!w_last_k) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                MM_WR_C: begin
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_last_j) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // MEM/WB boundary: bubble while stalled, retire the multiply from DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadData_w  <= '0;
            ALUResult_w <= '0;
            pcplus1_w   <= '0;
            destreg_w   <= '0;
            RegWrite_w  <= 1'b0;
            ResultSrc_w <= 1'b0;
            mm_done     <= 1'b0;
        end else if (mm_busy) begin
            RegWrite_w  <= 1'b0;
            ResultSrc_w <= 1'b0;
            mm_done     <= 1'b0;
        end else if (r_state == MM_DONE) begin
            ReadData_w  <= '0;
            ALUResult_w <= ALUResult_m;
            pcplus1_w   <= pcplus1_m;
            destreg_w   <= destreg_m;
            RegWrite_w  <= RegWrite_m;
            ResultSrc_w <= ResultSrc_m;
            mm_done     <= 1'b1;
        end else begin
            ReadData_w  <= w_rdata;
            ALUResult_w <= ALUResult_m;
            pcplus1_w   <= pcplus1_m;
            destreg_w   <= destreg_m;
            RegWrite_w  <= RegWrite_m;
            ResultSrc_w <= ResultSrc_m;
            mm_done     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, matrix-multiply corner
// sequences and randomized traffic against a byte-array reference model.
module tb_mem_stage;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ALUResult_m, WriteData_m, pcplus1_m;
    logic [2:0] destreg_m;
    logic       RegWrite_m, MemWrite_m, ResultSrc_m, is_matrix_mult_m;
    logic       mm_busy;
    logic [7:0] ReadData_w, ALUResult_w, pcplus1_w;
    logic [2:0] destreg_w;
    logic       RegWrite_w, ResultSrc_w, mm_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [256];

    typedef struct {
        bit         is_st;
        logic [7:0] addr;
        logic [7:0] val;
    } vec_t;

    vec_t       tab [14];
    logic [7:0] c_exp [4];

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ALUResult_m      (ALUResult_m),
        .WriteData_m      (WriteData_m),
        .pcplus1_m        (pcplus1_m),
        .destreg_m        (destreg_m),
        .RegWrite_m       (RegWrite_m),
        .MemWrite_m       (MemWrite_m),
        .ResultSrc_m      (ResultSrc_m),
        .is_matrix_mult_m (is_matrix_mult_m),
        .mm_busy          (mm_busy),
        .ReadData_w       (ReadData_w),
        .ALUResult_w      (ALUResult_w),
        .pcplus1_w        (pcplus1_w),
        .destreg_w        (destreg_w),
        .RegWrite_w       (RegWrite_w),
        .ResultSrc_w      (ResultSrc_w),
        .mm_done          (mm_done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        is_matrix_mult_m = 1'b0;
        MemWrite_m       = 1'b0;
        RegWrite_m       = 1'b0;
        ResultSrc_m      = 1'b0;
        WriteData_m      = 8'h00;
    endtask

    // Reference: C[r][c] = sum_k A[r][k]*B[k][c], each product and sum mod 256,
    // elements produced in row-major order against the current memory image.
    function automatic logic [7:0] ref_elem(input logic [7:0] base, input int r, input int c);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < 2; k++) begin
            s += ref_mem[8'(base + r * 2 + k)] * ref_mem[8'(base + 4 + k * 2 + c)];
        end
        return s;
    endfunction

    task automatic ref_mm(input logic [7:0] base, input int n_elems);
        for (int e = 0; e < n_elems; e++) begin
            ref_mem[8'(base + 8 + e)] = ref_elem(base, e / 2, e % 2);
        end
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        idle_inputs();
        ALUResult_m = a;
        WriteData_m = d;
        MemWrite_m  = 1'b1;
        step();
        ref_mem[a]  = d;
        MemWrite_m  = 1'b0;
    endtask

    task automatic do_load(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] pc;
        idle_inputs();
        pc          = a + 8'd1;
        ALUResult_m = a;
        RegWrite_m  = 1'b1;
        ResultSrc_m = 1'b1;
        destreg_m   = a[2:0];
        pcplus1_m   = pc;
        step();
        check(name, ReadData_w, exp);
        check({name, "_ctl"}, {RegWrite_w, ResultSrc_w, destreg_w, pcplus1_w, ALUResult_w},
              {1'b1, 1'b1, a[2:0], pc, a});
        RegWrite_m  = 1'b0;
        ResultSrc_m = 1'b0;
    endtask

    task automatic do_mm(input string name, input logic [7:0] base, input logic mw);
        int         busy;
        int         bad;
        logic [7:0] pc_hold;
        logic [7:0] pc;
        pc               = base ^ 8'h3C;
        pc_hold          = pcplus1_w;
        is_matrix_mult_m = 1'b1;
        ALUResult_m      = base;
        WriteData_m      = 8'h77;
        MemWrite_m       = mw;
        RegWrite_m       = 1'b1;
        ResultSrc_m      = 1'b1;
        destreg_m        = 3'd5;
        pcplus1_m        = pc;
        #1;
        busy = 0;
        bad  = 0;
        while (mm_busy && busy < 100) begin
            busy++;
            step();
            if (RegWrite_w !== 1'b0 || ResultSrc_w !== 1'b0 || mm_done !== 1'b0 ||
                pcplus1_w !== pc_hold) bad++;
        end
        check({name, "_busy_len"}, busy, 21);
        check({name, "_bubble"}, bad, 0);
        ref_mm(base, 4);
        step();
        check({name, "_done"}, mm_done, 1'b1);
        check({name, "_retire"}, {RegWrite_w, ResultSrc_w, destreg_w, ReadData_w, ALUResult_w, pcplus1_w},
              {1'b1, 1'b1, 3'd5, 8'h00, base, pc});
        idle_inputs();
        step();
        check({name, "_done_pulse"}, mm_done, 1'b0);
    endtask

    task automatic check_c(input string name, input logic [7:0] base);
        for (int e = 0; e < 4; e++) begin
            do_load($sformatf("%s_c%0d", name, e), 8'(base + 8 + e), ref_mem[8'(base + 8 + e)]);
        end
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] a;

        reset       = 1'b1;
        ALUResult_m = 8'h00;
        pcplus1_m   = 8'h00;
        destreg_m   = 3'd0;
        idle_inputs();
        for (int n = 0; n < 256; n++) ref_mem[n] = 8'h00;

        tab = '{
            '{1'b1, 8'h20, 8'hA5}, '{1'b0, 8'h20, 8'hA5},
            '{1'b1, 8'h21, 8'h3C}, '{1'b0, 8'h20, 8'hA5}, '{1'b0, 8'h21, 8'h3C},
            '{1'b1, 8'h10, 8'd1},  '{1'b1, 8'h11, 8'd2},  '{1'b1, 8'h12, 8'd3},
            '{1'b1, 8'h13, 8'd4},  '{1'b1, 8'h14, 8'd5},  '{1'b1, 8'h15, 8'd6},
            '{1'b1, 8'h16, 8'd7},  '{1'b1, 8'h17, 8'd8},  '{1'b0, 8'h13, 8'd4}
        };
        c_exp = '{8'd19, 8'd22, 8'd43, 8'd50};

        repeat (2) step();
        check("reset_outs", {ReadData_w, ALUResult_w, pcplus1_w, destreg_w, RegWrite_w, ResultSrc_w, mm_done}, 0);
        check("reset_busy", mm_busy, 1'b0);
        reset = 1'b0;

        for (int n = 0; n < 14; n++) begin
            if (tab[n].is_st) do_store(tab[n].addr, tab[n].val);
            else do_load($sformatf("vec%0d", n), tab[n].addr, tab[n].val);
        end

        do_mm("mm_basic", 8'h10, 1'b0);
        for (int e = 0; e < 4; e++) do_load($sformatf("mm_basic_c%0d", e), 8'(8'h18 + e), c_exp[e]);

        for (int e = 0; e < 8; e++) do_store(8'(8'h30 + e), 8'h0F);
        do_mm("mm_trunc", 8'h30, 1'b0);
        for (int e = 0; e < 4; e++) do_load($sformatf("mm_trunc_c%0d", e), 8'(8'h38 + e), 8'hC2);

        for (int e = 0; e < 8; e++) do_store(8'(8'hF8 + e), 8'($urandom));
        do_mm("mm_wrap", 8'hF8, 1'b0);
        check_c("mm_wrap", 8'hF8);

        for (int e = 0; e < 8; e++) do_store(8'(8'h40 + e), 8'(e + 8'h11));
        do_mm("mm_memwr", 8'h40, 1'b1);
        do_load("mm_memwr_nostore", 8'h40, 8'h11);
        check_c("mm_memwr", 8'h40);

        // Reset seven edges into a multiply: exactly C[0][0] has been written by then.
        for (int e = 0; e < 8; e++) do_store(8'(8'h50 + e), 8'($urandom_range(1, 255)));
        for (int e = 0; e < 4; e++) do_store(8'(8'h58 + e), 8'hEE);
        is_matrix_mult_m = 1'b1;
        ALUResult_m      = 8'h50;
        RegWrite_m       = 1'b1;
        ResultSrc_m      = 1'b1;
        repeat (7) step();
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_mid_outs", {ReadData_w, ALUResult_w, pcplus1_w, destreg_w, RegWrite_w, ResultSrc_w, mm_done}, 0);
        check("rst_mid_busy", mm_busy, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        ref_mm(8'h50, 1);
        check_c("rst_partial", 8'h50);
        do_mm("mm_after_rst", 8'h50, 1'b0);
        check_c("mm_after_rst", 8'h50);

        for (int t = 0; t < 5; t++) begin
            base = 8'($urandom);
            for (int e = 0; e < 8; e++) do_store(8'(base + e), 8'($urandom));
            do_mm($sformatf("mm_rand%0d", t), base, 1'($urandom));
            check_c($sformatf("mm_rand%0d", t), base);
        end

        for (int e = 0; e < 8; e++) do_store(8'(8'h80 + e), 8'($urandom));
        for (int t = 0; t < 40; t++) begin
            a = 8'(8'h80 + $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) do_store(a, 8'($urandom));
            else do_load($sformatf("rand_ld%0d", t), a, ref_mem[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
